pulse_voice: RTL and testbench
==============================

# pulse_voice

Pulse-wave tone generator that consumes the per-channel control stream produced by the note sequencers (`phase_delta`, `envelope`, `top`/`top_valid`) and turns it into a signed audio sample stream. It sits between a channel's note sequencer and the mixer. One instance is used per pulse channel. It runs a 32-bit phase accumulator at the sample rate. It applies a duty threshold derived from `top`, swapping that threshold only at waveform-cycle boundaries. It scales the wave by the envelope.

## Interface
Parameters:
- `SLEW_STEP`, default 1: amplitude change per sample strobe when slew is compiled in; range 1..511.
- `RESET_TOP`, default 8'hff: power-on/reset value of the pending and active `top` registers.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_sample_stb` in 1: single-cycle sample-rate strobe.
- `i_phase_delta` in 32: phase increment per sample; 0 means rest.
- `i_top` in 8: duty control value.
- `i_top_valid` in 1: `i_top` is captured into the pending register on any cycle this is high.
- `i_envelope` in 9: unsigned target amplitude.
- `o_sample` out 10: signed two's-complement sample.
- `o_sample_valid` out 1: one-cycle pulse, `o_sample` updated.
- `o_wrap` out 1: one-cycle pulse, accumulator wrapped (new waveform cycle).
- `o_active` out 1: high in RUN state.

## Operation
- State machine, two states:
  - IDLE: phase = 0, amplitude output forced to 0.
  - RUN: normal operation.
- Transitions, evaluated only on `i_sample_stb`:
  - IDLE→RUN when `i_phase_delta != 0`. On entry, the active top is loaded from pending, the phase accumulates from 0, and `o_wrap` pulses.
  - RUN→IDLE when `i_phase_delta == 0` and the applied amplitude is 0 after this strobe's update. On entry, phase is cleared to 0.
  - In RUN with `delta == 0` but amplitude still > 0 (slew only), phase is held and the target amplitude is 0.
- Phase: in RUN on strobe, `phase <= phase + delta` mod 2^32. A carry-out is a wrap.
  - On a wrap: active_top <= pending_top and `o_wrap` pulses.
  - If `i_top_valid` is high in the same cycle, the new `i_top` value is both written to pending and loaded into active.
- Duty: the wave is high when `phase[31:24] <= active_top[7:1]`, otherwise low. Example: 8'hff gives 128/256 high (50%); 8'h3f gives 32/256 high.
- Target amplitude = `i_envelope` in RUN with `delta != 0`, else 0.
- Applied amplitude is updated on each strobe:
  - Without slew: applied = target.
  - With slew: applied moves toward target by `SLEW_STEP`, clamped at target. No overshoot.
- Sample = `+amp` when high, `-amp` when low. Computed as a 10-bit sign-extension of the 9-bit amplitude, so there is no overflow (range −511..+511). In IDLE the sample is 0.
- `i_top_valid` is honoured in every state, including IDLE.

## Timing
- Strobe sampled at edge E0:
  - phase, state, amplitude, active_top and `o_wrap` update at E0.
  - `o_sample` and `o_sample_valid` register at E1 from the post-E0 values.
  - Latency is 2 edges from strobe to valid sample.
- `o_wrap` and `o_sample_valid` are high for exactly one cycle each.
- Strobes closer than 2 cycles apart are not supported.
- Reset values: state IDLE, phase 0, pending = active = `RESET_TOP`, amplitude 0, `o_sample` 0, `o_sample_valid` 0, `o_wrap` 0, `o_active` 0.
- Reset has priority over everything. A strobe or `top_valid` in a reset cycle is ignored. A pending E1 sample write is cancelled by reset.
- `o_active` reflects the registered state and changes at E0.

## Configuration
- `PULSE_VOICE_SLEW_EN`:
  - Defined: the slew limiter is present, amplitude ramps by `SLEW_STEP`, and RUN→IDLE waits for the amplitude to reach 0 (fade-out before phase reset).
  - Undefined: applied amplitude = target immediately. A rest strobe in RUN goes straight to IDLE. `SLEW_STEP` is unused.

## Test plan
- Slew off, reset, then delta = 0x0100_0000, top = 8'hff, env = 30, strobe every 4 cycles → `o_sample` +30 for 128 samples then −30 for 128. `o_wrap` pulses every 256 strobes. The first valid sample arrives 2 edges after the first strobe.
- Running at top = 8'hff, pulse `i_top_valid` with 8'h3f at sample 10 → duty stays 128 high until the next `o_wrap`, then 32 high / 224 low.
- Slew off, running with env = 30, strobe with delta = 0 → next `o_sample` = 0 and `o_active` = 0. Next strobe with a nonzero delta → `o_wrap` pulses and the first sample is +30.
- Slew on, `SLEW_STEP` = 2, env 0→30 → samples 2, 4, …, 30 over 15 strobes. Then delta = 0 → magnitudes 28, 26, …, 0, with `o_active` held high until the strobe that reaches 0.
- delta = 0xFFFF_FFFF from phase 0 → wrap on the 2nd strobe. With `i_top_valid` = 1 and `i_top` = 8'h01 in that strobe cycle → active top = 8'h01 at once (high only for phase[31:24] = 0).
- Assert `i_rst` on the cycle between a strobe and its sample → `o_sample_valid` stays 0, all outputs 0, top = `RESET_TOP`. A strobe coincident with reset is ignored.

Source files
------------

// File: rtl/pulse_voice.sv
`default_nettype none
// ============================================================================
// Module      : pulse_voice
// Description : Pulse-wave tone generator for one pulse channel. A 32-bit
//               phase accumulator advances by i_phase_delta on every sample
//               strobe. The wave is high while phase[31:24] <= top[7:1], and
//               the duty value (top) only changes at waveform-cycle
//               boundaries. The wave is scaled by the envelope into a signed
//               10-bit sample.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: PULSE_VOICE_SLEW_EN
//   defined   - the amplitude ramps toward its target by SLEW_STEP per
//               strobe, and a rest waits for the fade-out before returning
//               to IDLE.
//   undefined - the amplitude follows the target at once, and SLEW_STEP has
//               no effect.
// ----------------------------------------------------------------------------
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset, highest priority
//   i_sample_stb   single-cycle sample-rate strobe (min. 2 cycles apart)
//   i_phase_delta  phase increment per sample, 0 = rest
//   i_top          duty control value
//   i_top_valid    captures i_top into the pending duty register
//   i_envelope     unsigned target amplitude
//   o_sample       signed two's-complement sample (valid with o_sample_valid)
//   o_sample_valid one-cycle pulse, one edge after the strobe's update edge
//   o_wrap         one-cycle pulse at the start of each waveform cycle
//   o_active       high while the voice is in RUN
// ============================================================================
module pulse_voice #(
  parameter int unsigned SLEW_STEP = 1,
  parameter logic [7:0]  RESET_TOP = 8'hff
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sample_stb,
  input  logic [31:0] i_phase_delta,
  input  logic [7:0]  i_top,
  input  logic        i_top_valid,
  input  logic [8:0]  i_envelope,
  output logic [9:0]  o_sample,
  output logic        o_sample_valid,
  output logic        o_wrap,
  output logic        o_active
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [31:0] r_phase;
  logic [7:0]  r_pending_top;
  logic [7:0]  r_active_top;
  logic [8:0]  r_amp;
  logic        r_sample_due;   // a strobe was applied last edge; sample next

  // --------------------------------------------------------------------------
  // Combinational next-state values
  // --------------------------------------------------------------------------
  state_t      w_state_nxt;
  logic [31:0] w_phase_nxt;
  logic [7:0]  w_active_nxt;
  logic [8:0]  w_amp_nxt;
  logic        w_wrap_nxt;
  logic        w_delta_nz;
  logic [8:0]  w_target;
  logic [32:0] w_phase_sum;
  logic [7:0]  w_load_top;
  logic [8:0]  w_amp_slew;     // amplitude after this strobe's update
  logic        w_high;
  logic [9:0]  w_amp_ext;
  logic [9:0]  w_sample_nxt;

  // A step outside 1..511 is meaningless for a 9-bit amplitude; such a
  // build shows up as this scope in the elaborated hierarchy.
  if ((SLEW_STEP < 1) || (SLEW_STEP > 511)) begin : g_slew_step_out_of_range
  end

  // --------------------------------------------------------------------------
  // Shared terms
  // --------------------------------------------------------------------------
  always_comb begin
    w_delta_nz  = |i_phase_delta;
    // A nonzero delta either keeps RUN or enters it on this strobe, so the
    // envelope is the target in both cases; a rest always targets silence.
    w_target    = w_delta_nz ? i_envelope : 9'd0;
    w_phase_sum = {1'b0, r_phase} + {1'b0, i_phase_delta};
    // A top written in the same cycle as a load takes effect immediately.
    w_load_top  = i_top_valid ? i_top : r_pending_top;
  end

  // --------------------------------------------------------------------------
  // Amplitude update
  // --------------------------------------------------------------------------
`ifdef PULSE_VOICE_SLEW_EN
  localparam logic [9:0] c_slew_step = 10'(SLEW_STEP);

  logic [9:0] w_up_sum;
  logic [9:0] w_down_gap;

  always_comb begin
    w_up_sum   = {1'b0, r_amp} + c_slew_step;
    w_down_gap = {1'b0, r_amp} - {1'b0, w_target};
    w_amp_slew = r_amp;
    if (r_amp < w_target) begin
      // Rising: clamp at the target so the ramp never overshoots.
      if (w_up_sum >= {1'b0, w_target}) begin
        w_amp_slew = w_target;
      end else begin
        w_amp_slew = w_up_sum[8:0];
      end
    end else if (r_amp > w_target) begin
      // Falling: the gap test keeps the subtraction from wrapping below 0.
      if (w_down_gap <= c_slew_step) begin
        w_amp_slew = w_target;
      end else begin
        w_amp_slew = r_amp - c_slew_step[8:0];
      end
    end
  end
`else
  always_comb begin
    w_amp_slew = w_target;
  end
`endif

  // --------------------------------------------------------------------------
  // FSM next-state and datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_active_nxt = r_active_top;
    w_amp_nxt    = r_amp;
    w_wrap_nxt   = 1'b0;

    if (i_sample_stb) begin
      w_amp_nxt = w_amp_slew;
      case (r_state)
        ST_IDLE: begin
          if (w_delta_nz) begin
            // Phase is 0 in IDLE, so the first step lands on delta itself.
            w_state_nxt  = ST_RUN;
            w_phase_nxt  = i_phase_delta;
            w_active_nxt = w_load_top;
            w_wrap_nxt   = 1'b1;
          end else begin
            w_phase_nxt = 32'd0;
          end
        end
        ST_RUN: begin
          if (w_delta_nz) begin
            w_phase_nxt = w_phase_sum[31:0];
            if (w_phase_sum[32]) begin
              w_active_nxt = w_load_top;
              w_wrap_nxt   = 1'b1;
            end
          end else if (w_amp_slew == 9'd0) begin
            // Rest and fully faded: restart the waveform from phase 0.
            w_state_nxt = ST_IDLE;
            w_phase_nxt = 32'd0;
          end
          // Rest while still fading: phase holds, amplitude keeps falling.
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = 32'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output sample, computed from the values committed at the strobe edge
  // --------------------------------------------------------------------------
  always_comb begin
    w_high       = (r_phase[31:24] <= {1'b0, r_active_top[7:1]});
    w_amp_ext    = {1'b0, r_amp};
    w_sample_nxt = 10'd0;
    if (r_state == ST_RUN) begin
      w_sample_nxt = w_high ? w_amp_ext : (10'd0 - w_amp_ext);
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase        <= 32'd0;
      r_pending_top  <= RESET_TOP;
      r_active_top   <= RESET_TOP;
      r_amp          <= 9'd0;
      r_sample_due   <= 1'b0;
      o_sample       <= 10'd0;
      o_sample_valid <= 1'b0;
      o_wrap         <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_active_top <= w_active_nxt;
      r_amp        <= w_amp_nxt;
      r_sample_due <= i_sample_stb;
      o_wrap       <= w_wrap_nxt;
      if (i_top_valid) begin
        r_pending_top <= i_top;
      end
      o_sample_valid <= r_sample_due;
      if (r_sample_due) begin
        o_sample <= w_sample_nxt;
      end
    end
  end

  assign o_active = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_pulse_voice.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_voice
// Description : Self-checking bench for pulse_voice. A vector table covers
//               the duty, wrap and rest behaviour strobe by strobe; hand-
//               written sequences cover a long waveform run, the slew ramp
//               (PULSE_VOICE_SLEW_EN builds) and reset in the middle of a
//               sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_voice;

`ifdef PULSE_VOICE_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_sample_stb;
  logic [31:0] i_phase_delta;
  logic [7:0]  i_top;
  logic        i_top_valid;
  logic [8:0]  i_envelope;
  logic [9:0]  o_sample;
  logic        o_sample_valid;
  logic        o_wrap;
  logic        o_active;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pulse_voice #(
    .SLEW_STEP (2),
    .RESET_TOP (8'hff)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_sample_stb   (i_sample_stb),
    .i_phase_delta  (i_phase_delta),
    .i_top          (i_top),
    .i_top_valid    (i_top_valid),
    .i_envelope     (i_envelope),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .o_wrap         (o_wrap),
    .o_active       (o_active)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  top;
    logic        tv;
    logic [8:0]  env;
    int          exp_smp;
    logic        exp_wrap;
    logic        exp_act;
  } vec_t;

  vec_t vt[19];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expected amplitude k strobes into a note from silence.
  function automatic int ramp(input int k, input int env);
    return (SLEW_ON && (2 * k < env)) ? 2 * k : env;
  endfunction

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst        = 1'b1;
    i_sample_stb = 1'b0;
    i_top_valid  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("reset_sample", 32'($signed(o_sample)), 0);
    check("reset_valid", 32'(o_sample_valid), 0);
    check("reset_wrap", 32'(o_wrap), 0);
    check("reset_active", 32'(o_active), 0);
  endtask

  // One strobe: wrap/active are sampled after the update edge, the sample
  // one edge later.
  task automatic do_strobe(input logic [31:0] d, input logic [7:0] top,
                           input logic tv, input logic [8:0] env,
                           output logic signed [31:0] smp,
                           output logic wrap, output logic act);
    @(posedge i_clk); #1;
    check("valid_between", 32'(o_sample_valid), 0);
    i_phase_delta = d;
    i_top         = top;
    i_top_valid   = tv;
    i_envelope    = env;
    i_sample_stb  = 1'b1;
    @(posedge i_clk); #1;
    i_sample_stb = 1'b0;
    i_top_valid  = 1'b0;
    wrap = o_wrap;
    act  = o_active;
    check("valid_at_e0", 32'(o_sample_valid), 0);
    @(posedge i_clk); #1;
    check("valid_at_e1", 32'(o_sample_valid), 1);
    check("wrap_one_cycle", 32'(o_wrap), 0);
    smp = 32'($signed(o_sample));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [31:0] smp;
    logic wrap, act;

    i_rst         = 1'b1;
    i_sample_stb  = 1'b0;
    i_phase_delta = 32'd0;
    i_top         = 8'hff;
    i_top_valid   = 1'b0;
    i_envelope    = 9'd0;

    // ------------------------------------------------------------------
    // Vector table (slew off): duty, same-cycle top load, rest/restart
    // ------------------------------------------------------------------
    vt[0]  = '{32'h0000_0000, 8'hff, 1'b0, 9'd30,     0, 1'b0, 1'b0};
    vt[1]  = '{32'h4000_0000, 8'hff, 1'b0, 9'd30,    30, 1'b1, 1'b1};
    vt[2]  = '{32'h4000_0000, 8'hff, 1'b0, 9'd30,   -30, 1'b0, 1'b1};
    vt[3]  = '{32'h4000_0000, 8'hff, 1'b0, 9'd100, -100, 1'b0, 1'b1};
    vt[4]  = '{32'h4000_0000, 8'h3f, 1'b1, 9'd100,  100, 1'b1, 1'b1};
    vt[5]  = '{32'h1000_0000, 8'hff, 1'b0, 9'd100,  100, 1'b0, 1'b1};
    vt[6]  = '{32'h1000_0000, 8'hff, 1'b0, 9'd100, -100, 1'b0, 1'b1};
    vt[7]  = '{32'h1000_0000, 8'h1f, 1'b1, 9'd511, -511, 1'b0, 1'b1};
    vt[8]  = '{32'hD000_0000, 8'hff, 1'b0, 9'd511,  511, 1'b1, 1'b1};
    vt[9]  = '{32'h1000_0000, 8'hff, 1'b0, 9'd511, -511, 1'b0, 1'b1};
    vt[10] = '{32'h0000_0000, 8'hff, 1'b0, 9'd511,    0, 1'b0, 1'b0};
    vt[11] = '{32'h0000_0000, 8'hff, 1'b1, 9'd50,     0, 1'b0, 1'b0};
    vt[12] = '{32'hFFFF_FFFF, 8'hff, 1'b0, 9'd50,   -50, 1'b1, 1'b1};
    vt[13] = '{32'hFFFF_FFFF, 8'h01, 1'b1, 9'd50,   -50, 1'b1, 1'b1};
    vt[14] = '{32'h0100_0002, 8'hff, 1'b0, 9'd50,   -50, 1'b1, 1'b1};
    vt[15] = '{32'hFF00_0000, 8'hff, 1'b0, 9'd50,    50, 1'b1, 1'b1};
    vt[16] = '{32'h0100_0000, 8'hff, 1'b0, 9'd50,   -50, 1'b0, 1'b1};
    vt[17] = '{32'h0000_0000, 8'hff, 1'b1, 9'd50,     0, 1'b0, 1'b0};
    vt[18] = '{32'h0100_0000, 8'hff, 1'b0, 9'd30,    30, 1'b1, 1'b1};

    do_reset();

`ifndef PULSE_VOICE_SLEW_EN
    for (int i = 0; i < 19; i++) begin
      do_strobe(vt[i].d, vt[i].top, vt[i].tv, vt[i].env, smp, wrap, act);
      check($sformatf("vec%0d_sample", i), smp, vt[i].exp_smp);
      check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vt[i].exp_wrap));
      check($sformatf("vec%0d_active", i), 32'(act), 32'(vt[i].exp_act));
    end
`endif

    // ------------------------------------------------------------------
    // Long run: 50% duty, top 8'h3f written at sample 10, taking effect
    // only at the wrap on strobe 256 (then 32 high per cycle).
    // ------------------------------------------------------------------
    do_reset();
    begin
      int wraps;
      int highs;
      wraps = 0;
      highs = 0;
      for (int k = 1; k <= 300; k++) begin
        int byte_v;
        int thr;
        int amp;
        int exp_s;
        byte_v = k % 256;
        thr    = (k >= 256) ? 31 : 127;
        amp    = ramp(k, 30);
        exp_s  = (byte_v <= thr) ? amp : -amp;
        do_strobe(32'h0100_0000, (k == 10) ? 8'h3f : 8'hff, (k == 10),
                  9'd30, smp, wrap, act);
        check($sformatf("run%0d_sample", k), smp, exp_s);
        check($sformatf("run%0d_wrap", k), 32'(wrap),
              ((k == 1) || (k == 256)) ? 1 : 0);
        if (wrap) wraps++;
        if ((k < 256) && (smp > 0)) highs++;
      end
      check("run_wrap_count", wraps, 2);
      check("run_high_count_first_cycle", highs, 127);
    end

`ifdef PULSE_VOICE_SLEW_EN
    // ------------------------------------------------------------------
    // Slew ramp up by 2 to 30, then fade to 0 on rest with phase held
    // ------------------------------------------------------------------
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      do_strobe(32'h0100_0000, 8'hff, 1'b0, 9'd30, smp, wrap, act);
      check($sformatf("rise%0d_sample", k), smp, 2 * k);
      check($sformatf("rise%0d_active", k), 32'(act), 1);
    end
    for (int j = 1; j <= 14; j++) begin
      do_strobe(32'h0000_0000, 8'hff, 1'b0, 9'd30, smp, wrap, act);
      check($sformatf("fall%0d_sample", j), smp, 30 - 2 * j);
      check($sformatf("fall%0d_active", j), 32'(act), (j < 15 - 0 && 30 - 2 * j > 0) ? 1 : 0);
      check($sformatf("fall%0d_wrap", j), 32'(wrap), 0);
    end
    do_strobe(32'h0000_0000, 8'hff, 1'b0, 9'd30, smp, wrap, act);
    check("rest_sample", smp, 0);
    check("rest_active", 32'(act), 0);
`endif

    // ------------------------------------------------------------------
    // Reset between strobe and sample; strobe/top_valid during reset
    // ------------------------------------------------------------------
    do_reset();
    @(posedge i_clk); #1;
    i_phase_delta = 32'h0100_0000;
    i_envelope    = 9'd30;
    i_top         = 8'hff;
    i_sample_stb  = 1'b1;
    @(posedge i_clk); #1;
    i_sample_stb = 1'b0;
    check("rst_pre_active", 32'(o_active), 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("rst_cancel_valid", 32'(o_sample_valid), 0);
    check("rst_cancel_sample", 32'($signed(o_sample)), 0);
    check("rst_cancel_active", 32'(o_active), 0);
    check("rst_cancel_wrap", 32'(o_wrap), 0);
    i_sample_stb  = 1'b1;
    i_top_valid   = 1'b1;
    i_top         = 8'h00;
    i_phase_delta = 32'h7F00_0000;
    @(posedge i_clk); #1;
    i_sample_stb = 1'b0;
    i_top_valid  = 1'b0;
    i_rst        = 1'b0;
    check("rst_stb_active", 32'(o_active), 0);
    check("rst_stb_wrap", 32'(o_wrap), 0);
    do_strobe(32'h7F00_0000, 8'hff, 1'b0, 9'd40, smp, wrap, act);
    check("post_rst_sample", smp, ramp(1, 40));
    check("post_rst_wrap", 32'(wrap), 1);
    check("post_rst_active", 32'(act), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
